// File: rtl/axil_initiator_adaptor_if.sv
// AXI4-Lite channel bundle between a manager (initiator) and a subordinate.
// The master modport is the initiator side; the slave modport is the subordinate side.
interface axil_initiator_adaptor_if #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
);
  localparam int unsigned strb_width_lp = data_width_p / 8;

  logic [addr_width_p-1:0]  awaddr;
  logic [2:0]               awprot;
  logic                     awvalid;
  logic                     awready;

  logic [data_width_p-1:0]  wdata;
  logic [strb_width_lp-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;

  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  logic [addr_width_p-1:0]  araddr;
  logic [2:0]               arprot;
  logic                     arvalid;
  logic                     arready;

  logic [data_width_p-1:0]  rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );
endinterface

// File: rtl/axil_initiator_adaptor.sv
// AXI4-Lite initiator: turns one valid/ready request into a single AXI-Lite read or write.
// Optional AXIL_INITIATOR_ERR_CAPTURE_EN adds sticky capture of the first failing address.
module axil_initiator_adaptor #(
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         v_i,
  output logic                         ready_and_o,
  input  logic [axil_addr_width_p-1:0] addr_i,
  input  logic                         wr_en_i,
  input  logic [1:0]                   data_size_i,
  input  logic [axil_data_width_p-1:0] wdata_i,

  output logic                         v_o,
  input  logic                         ready_and_i,
  output logic [axil_data_width_p-1:0] rdata_o,
  output logic                         err_o,

  axil_initiator_adaptor_if.master     m_axil
`ifdef AXIL_INITIATOR_ERR_CAPTURE_EN
  ,
  output logic [axil_addr_width_p-1:0] err_addr_o,
  output logic                         err_v_o,
  input  logic                         err_clear_i
`endif
);

  localparam int unsigned dw_lp = axil_data_width_p;
  localparam int unsigned aw_lp = axil_addr_width_p;
  localparam int unsigned sw_lp = axil_data_width_p / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RD,
    ST_RR,
    ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [aw_lp-1:0]   addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic [dw_lp-1:0]   wdata_q, wdata_d;
  logic [sw_lp-1:0]   wstrb_q, wstrb_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic               bready_q, bready_d;
  logic               rready_q, rready_d;
  logic               v_q, v_d;
  logic               err_q, err_d;
  logic [dw_lp-1:0]   rdata_q, rdata_d;
  logic               ready_q, ready_d;

  // Replicate the low bytes so the active lanes carry data whatever the offset.
  function automatic logic [dw_lp-1:0] pack_wdata(input logic [dw_lp-1:0] d,
                                                  input logic [1:0] sz);
    case (sz)
      2'd0:    return dw_lp'({4{d[7:0]}});
      2'd1:    return dw_lp'({2{d[15:0]}});
      default: return d;
    endcase
  endfunction

  function automatic logic [sw_lp-1:0] gen_wstrb(input logic [1:0] off,
                                                 input logic [1:0] sz);
    case (sz)
      2'd0:    return sw_lp'(4'b0001) << off;
      2'd1:    return sw_lp'(4'b0011) << {off[1], 1'b0};
      default: return sw_lp'(4'b1111);
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 and zero the bytes beyond the access size.
  function automatic logic [dw_lp-1:0] extract_rdata(input logic [dw_lp-1:0] d,
                                                     input logic [1:0] off,
                                                     input logic [1:0] sz);
    logic [dw_lp-1:0] s;
    s = d >> {off, 3'b000};
    case (sz)
      2'd0:    return s & dw_lp'(32'h0000_00FF);
      2'd1:    return s & dw_lp'(32'h0000_FFFF);
      default: return s;
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      v_q       <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      v_q       <= v_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    v_d       = v_q;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (v_i && ready_q) begin
          addr_d  = addr_i;
          size_d  = data_size_i;
          wdata_d = pack_wdata(wdata_i, data_size_i);
          wstrb_d = gen_wstrb(addr_i[1:0], data_size_i);
          rdata_d = '0;
          err_d   = 1'b0;
          if (is_misaligned(addr_i[1:0], data_size_i)) begin
            err_d   = 1'b1;
            v_d     = 1'b1;
            state_d = ST_RESP;
          end else if (wr_en_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD;
          end
        end
      end

      ST_WR: begin
        if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WB;
        end
      end

      ST_WB: begin
        if (bready_q && m_axil.bvalid) begin
          bready_d = 1'b0;
          err_d    = (m_axil.bresp != 2'b00);
          v_d      = 1'b1;
          state_d  = ST_RESP;
        end
      end

      ST_RD: begin
        if (arvalid_q && m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RR;
        end
      end

      ST_RR: begin
        if (rready_q && m_axil.rvalid) begin
          rready_d = 1'b0;
          err_d    = (m_axil.rresp != 2'b00);
          rdata_d  = extract_rdata(m_axil.rdata, addr_q[1:0], size_q);
          v_d      = 1'b1;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        if (ready_and_i) begin
          v_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign ready_and_o    = ready_q;
  assign v_o            = v_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

`ifdef AXIL_INITIATOR_ERR_CAPTURE_EN
  logic             err_v_q;
  logic [aw_lp-1:0] err_addr_q;
  logic             err_done;

  assign err_done = v_q && ready_and_i && err_q;

  // A fresh error beats a simultaneous clear so that no failure goes unrecorded.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_v_q    <= 1'b0;
      err_addr_q <= '0;
    end else if (err_done && (!err_v_q || err_clear_i)) begin
      err_v_q    <= 1'b1;
      err_addr_q <= addr_q;
    end else if (err_clear_i) begin
      err_v_q    <= 1'b0;
    end
  end

  assign err_v_o    = err_v_q;
  assign err_addr_o = err_addr_q;
`endif

  // A response before its request channels completed is a subordinate protocol violation.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(m_axil.bvalid && (state_q inside {ST_WR, ST_RD, ST_RR})));
      assert (!(m_axil.rvalid && (state_q inside {ST_RD, ST_WR, ST_WB})));
    end
  end

endmodule

// File: tb/tb_axil_initiator_adaptor.sv
// Directed bench for axil_initiator_adaptor with a small behavioural AXI-Lite subordinate.
// Define AXIL_INITIATOR_ERR_CAPTURE_EN to also exercise the error-capture ports.
module tb_axil_initiator_adaptor;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_and_o;
  logic [31:0] addr_i = '0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  data_size_i = '0;
  logic [31:0] wdata_i = '0;
  logic        v_o;
  logic        ready_and_i = 1'b0;
  logic [31:0] rdata_o;
  logic        err_o;
`ifdef AXIL_INITIATOR_ERR_CAPTURE_EN
  logic [31:0] err_addr_o;
  logic        err_v_o;
  logic        err_clear_i = 1'b0;
`endif

  axil_initiator_adaptor_if m_axil ();

  axil_initiator_adaptor dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .addr_i      (addr_i),
    .wr_en_i     (wr_en_i),
    .data_size_i (data_size_i),
    .wdata_i     (wdata_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .m_axil      (m_axil)
`ifdef AXIL_INITIATOR_ERR_CAPTURE_EN
    ,
    .err_addr_o  (err_addr_o),
    .err_v_o     (err_v_o),
    .err_clear_i (err_clear_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Subordinate knobs and observations.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic [31:0] rdata_k = '0;
  logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
  logic [3:0]  seen_wstrb;
  logic [2:0]  seen_awprot, seen_arprot;
  logic        ever_aw, ever_ar, aw_alone;
  int          w_hi, stab_err = 0;

  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_done, w_done, ar_done, b_hs, r_hs;
  logic        prev_awv, prev_wv, prev_arv;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  logic [3:0]  prev_wstrb;

  // Subordinate: drives on the falling edge, so the values seen here are what the DUT samples next.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      m_axil.awready = 1'b0; m_axil.wready = 1'b0; m_axil.arready = 1'b0;
      m_axil.bvalid = 1'b0;  m_axil.bresp = 2'b00;
      m_axil.rvalid = 1'b0;  m_axil.rresp = 2'b00; m_axil.rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
      prev_awv = 1'b0; prev_wv = 1'b0; prev_arv = 1'b0;
    end else begin
      if (b_hs) begin
        m_axil.bvalid = 1'b0; b_hs = 1'b0;
      end else if (m_axil.bvalid) begin
        b_hs = m_axil.bready;
      end else if (aw_done && w_done) begin
        m_axil.bvalid = 1'b1; m_axil.bresp = bresp_k;
        aw_done = 1'b0; w_done = 1'b0;
        b_hs = m_axil.bready;
      end

      if (r_hs) begin
        m_axil.rvalid = 1'b0; r_hs = 1'b0;
      end else if (m_axil.rvalid) begin
        r_hs = m_axil.rready;
      end else if (ar_done) begin
        m_axil.rvalid = 1'b1; m_axil.rresp = rresp_k; m_axil.rdata = rdata_k;
        ar_done = 1'b0;
        r_hs = m_axil.rready;
      end

      m_axil.awready = 1'b0;
      if (m_axil.awvalid && !aw_done) begin
        if (aw_cnt >= aw_lat) begin
          m_axil.awready = 1'b1; aw_done = 1'b1;
          seen_awaddr = m_axil.awaddr; seen_awprot = m_axil.awprot;
        end
        aw_cnt++;
      end else aw_cnt = 0;

      m_axil.wready = 1'b0;
      if (m_axil.wvalid && !w_done) begin
        if (w_cnt >= w_lat) begin
          m_axil.wready = 1'b1; w_done = 1'b1;
          seen_wdata = m_axil.wdata; seen_wstrb = m_axil.wstrb;
        end
        w_cnt++;
      end else w_cnt = 0;

      m_axil.arready = 1'b0;
      if (m_axil.arvalid && !ar_done) begin
        if (ar_cnt >= ar_lat) begin
          m_axil.arready = 1'b1; ar_done = 1'b1;
          seen_araddr = m_axil.araddr; seen_arprot = m_axil.arprot;
        end
        ar_cnt++;
      end else ar_cnt = 0;

      ever_aw  = ever_aw | m_axil.awvalid;
      ever_ar  = ever_ar | m_axil.arvalid;
      aw_alone = aw_alone | (m_axil.wvalid && !m_axil.awvalid);
      if (m_axil.wvalid) w_hi++;
      if (prev_awv && m_axil.awvalid && m_axil.awaddr !== prev_awaddr) stab_err++;
      if (prev_wv && m_axil.wvalid &&
          (m_axil.wdata !== prev_wdata || m_axil.wstrb !== prev_wstrb)) stab_err++;
      if (prev_arv && m_axil.arvalid && m_axil.araddr !== prev_araddr) stab_err++;
      prev_awv = m_axil.awvalid; prev_awaddr = m_axil.awaddr;
      prev_wv  = m_axil.wvalid;  prev_wdata = m_axil.wdata; prev_wstrb = m_axil.wstrb;
      prev_arv = m_axil.arvalid; prev_araddr = m_axil.araddr;
    end
  end

  logic [31:0] rd;
  logic        er;
  int          lat, unst;

  // One request/response; lat is cycles from acceptance to the first cycle with v_o high.
  task automatic do_req(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] r, output logic e, output int l, output int u);
    int c0, n;
    ever_aw = 1'b0; ever_ar = 1'b0; aw_alone = 1'b0; w_hi = 0;
    @(negedge clk_i);
    v_i = 1'b1; addr_i = a; wr_en_i = wr; data_size_i = sz; wdata_i = wd;
    n = 0;
    while (!ready_and_o && n < 20) begin @(negedge clk_i); n++; end
    if (!ready_and_o) chk("accept_timeout", 32'(ready_and_o), 32'd1);
    c0 = cyc;
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    while (!v_o && n < 60) begin @(negedge clk_i); n++; end
    if (!v_o) chk("resp_timeout", 32'(v_o), 32'd1);
    r = rdata_o; e = err_o; l = cyc - c0; u = 0;
    repeat (hold) begin
      @(negedge clk_i);
      if (!v_o || rdata_o !== r || err_o !== e) u++;
    end
    ready_and_i = 1'b1;
    @(negedge clk_i);
    ready_and_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 32'(ready_and_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_valids", {29'd0, m_axil.awvalid, m_axil.wvalid, m_axil.arvalid}, 32'd0);
    chk("rst_readies", {30'd0, m_axil.bready, m_axil.rready}, 32'd0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("idle_ready", 32'(ready_and_o), 32'd1);

`ifdef AXIL_INITIATOR_ERR_CAPTURE_EN
    chk("cap_rst_v", 32'(err_v_o), 32'd0);
    chk("cap_rst_addr", err_addr_o, 32'd0);
    bresp_k = 2'b10;
    do_req(32'h10, 1'b1, 2'd2, 32'h1, 0, rd, er, lat, unst);
    chk("cap_w1_err", 32'(er), 32'd1);
    do_req(32'h20, 1'b1, 2'd2, 32'h2, 0, rd, er, lat, unst);
    chk("cap_w2_err", 32'(er), 32'd1);
    chk("cap_v", 32'(err_v_o), 32'd1);
    chk("cap_addr_first", err_addr_o, 32'h10);
    err_clear_i = 1'b1;
    @(negedge clk_i);
    err_clear_i = 1'b0;
    chk("cap_cleared", 32'(err_v_o), 32'd0);
    bresp_k = 2'b00;
`endif

    // Word write, zero-wait subordinate.
    do_req(32'h40, 1'b1, 2'd2, 32'hDEADBEEF, 0, rd, er, lat, unst);
    chk("ww_awaddr", seen_awaddr, 32'h40);
    chk("ww_wdata", seen_wdata, 32'hDEADBEEF);
    chk("ww_wstrb", 32'(seen_wstrb), 32'hF);
    chk("ww_awprot", 32'(seen_awprot), 32'd0);
    chk("ww_lat", 32'(lat), 32'd3);
    chk("ww_err", 32'(er), 32'd0);
    chk("ww_rdata", rd, 32'd0);
    chk("ww_v_dropped", 32'(v_o), 32'd0);
    chk("ww_ready_again", 32'(ready_and_o), 32'd1);

    // Byte write to lane 3.
    do_req(32'h43, 1'b1, 2'd0, 32'h000000A5, 0, rd, er, lat, unst);
    chk("bw_awaddr", seen_awaddr, 32'h43);
    chk("bw_wdata", seen_wdata, 32'hA5A5A5A5);
    chk("bw_wstrb", 32'(seen_wstrb), 32'b1000);
    chk("bw_lat", 32'(lat), 32'd3);

    // Halfword read from the upper half.
    rdata_k = 32'h1234ABCD;
    do_req(32'h102, 1'b0, 2'd1, 32'h0, 0, rd, er, lat, unst);
    chk("hr_araddr", seen_araddr, 32'h102);
    chk("hr_arprot", 32'(seen_arprot), 32'd0);
    chk("hr_rdata", rd, 32'h00001234);
    chk("hr_err", 32'(er), 32'd0);
    chk("hr_lat", 32'(lat), 32'd3);

    // Byte read from lane 1.
    do_req(32'h101, 1'b0, 2'd0, 32'h0, 0, rd, er, lat, unst);
    chk("br_rdata", rd, 32'h000000AB);

    // Halfword write with W accepted five cycles late and the response held off.
    w_lat = 5;
    do_req(32'h22, 1'b1, 2'd1, 32'h0000BEEF, 3, rd, er, lat, unst);
    chk("dw_wdata", seen_wdata, 32'hBEEFBEEF);
    chk("dw_wstrb", 32'(seen_wstrb), 32'b1100);
    chk("dw_aw_first", 32'(aw_alone), 32'd1);
    chk("dw_w_hold", 32'(w_hi), 32'd6);
    chk("dw_lat", 32'(lat), 32'd8);
    chk("dw_resp_stable", 32'(unst), 32'd0);
    chk("dw_err", 32'(er), 32'd0);
    w_lat = 0;

    // Misaligned word read: no AR traffic, immediate error.
    do_req(32'h06, 1'b0, 2'd2, 32'h0, 0, rd, er, lat, unst);
    chk("ma_no_ar", 32'(ever_ar), 32'd0);
    chk("ma_err", 32'(er), 32'd1);
    chk("ma_rdata", rd, 32'd0);
    chk("ma_lat", 32'(lat), 32'd1);

    // Read answered with SLVERR; data still captured.
    rresp_k = 2'b10; rdata_k = 32'hCAFEF00D;
    do_req(32'h08, 1'b0, 2'd2, 32'h0, 0, rd, er, lat, unst);
    chk("re_err", 32'(er), 32'd1);
    chk("re_rdata", rd, 32'hCAFEF00D);
    rresp_k = 2'b00;

    // Write answered with DECERR.
    bresp_k = 2'b11;
    do_req(32'h0C, 1'b1, 2'd2, 32'h55, 0, rd, er, lat, unst);
    chk("we_err", 32'(er), 32'd1);
    chk("we_lat", 32'(lat), 32'd3);
    bresp_k = 2'b00;

    // Illegal size and misaligned halfword writes never reach AW.
    do_req(32'h00, 1'b1, 2'd3, 32'h1, 0, rd, er, lat, unst);
    chk("sz3_no_aw", 32'(ever_aw), 32'd0);
    chk("sz3_err", 32'(er), 32'd1);
    do_req(32'h01, 1'b1, 2'd1, 32'h1, 0, rd, er, lat, unst);
    chk("mh_no_aw", 32'(ever_aw), 32'd0);
    chk("mh_err", 32'(er), 32'd1);

    // Clean transaction after errors clears err_o.
    do_req(32'h44, 1'b1, 2'd2, 32'h0, 0, rd, er, lat, unst);
    chk("ok_after_err", 32'(er), 32'd0);

    chk("valid_payload_stable", 32'(stab_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
